// File: rtl/udl_counter_mod.sv
// udl_counter_mod: up/down/loadable modulo counter with wrap/saturate modes,
// cascade terminal count, one-cycle wrap pulse and sticky limit flag.
module udl_counter_mod #(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 2**WIDTH-1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             L,
    input  logic [WIDTH-1:0] D,
    input  logic             En,
    input  logic             up,
    input  logic             sat,
    input  logic             clr_flag,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             wrap,
    output logic             limit
);
    if (WIDTH < 1 || MAX_VAL < 1 || MAX_VAL > 2**WIDTH-1) begin : g_bad_param
        $error("udl_counter_mod: MAX_VAL must be in 1..2**WIDTH-1");
    end

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             limit_q, limit_d;
    logic             at_max, at_zero;

    assign at_max  = q_q == MAX;
    assign at_zero = q_q == '0;

    always_comb begin
        q_d     = q_q;
        wrap_d  = 1'b0;
        limit_d = limit_q & ~clr_flag;
        if (L) begin
            q_d = (D > MAX) ? MAX : D;
        end else if (En && up) begin
            q_d     = !at_max ? q_q + 1'b1 : (sat ? q_q : '0);
            wrap_d  = at_max & ~sat;
            limit_d = limit_d | at_max;
        end else if (En) begin
            q_d     = !at_zero ? q_q - 1'b1 : (sat ? q_q : MAX);
            wrap_d  = at_zero & ~sat;
            limit_d = limit_d | at_zero;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_q     <= '0;
            wrap_q  <= 1'b0;
            limit_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            wrap_q  <= wrap_d;
            limit_q <= limit_d;
        end
    end

    assign Q     = q_q;
    assign wrap  = wrap_q;
    assign limit = limit_q;
    assign tc    = En & (up ? at_max : at_zero);
endmodule

// File: tb/tb_udl_counter_mod.sv
// tb_udl_counter_mod: directed checks of a 3-bit mod-6 counter and a
// two-digit decimal cascade built from mod-10 instances.
module tb_udl_counter_mod;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, L, En, up, sat, clr_flag;
    logic [2:0] D, Q;
    logic       tc, wrap, limit;

    logic       c_reset, c_en, lo_tc, hi_tc, lo_wrap, hi_wrap, lo_lim, hi_lim;
    logic [3:0] lo_q, hi_q;

    int passed = 0;
    int total  = 0;

    udl_counter_mod #(.WIDTH(3), .MAX_VAL(5)) dut (
        .clk(clk), .reset(reset), .L(L), .D(D), .En(En), .up(up), .sat(sat),
        .clr_flag(clr_flag), .Q(Q), .tc(tc), .wrap(wrap), .limit(limit)
    );

    udl_counter_mod #(.WIDTH(4), .MAX_VAL(9)) u_lo (
        .clk(clk), .reset(c_reset), .L(1'b0), .D(4'd0), .En(c_en), .up(1'b1),
        .sat(1'b0), .clr_flag(1'b0), .Q(lo_q), .tc(lo_tc), .wrap(lo_wrap), .limit(lo_lim)
    );

    udl_counter_mod #(.WIDTH(4), .MAX_VAL(9)) u_hi (
        .clk(clk), .reset(c_reset), .L(1'b0), .D(4'd0), .En(lo_tc), .up(1'b1),
        .sat(1'b0), .clr_flag(1'b0), .Q(hi_q), .tc(hi_tc), .wrap(hi_wrap), .limit(hi_lim)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; L = 1'b0; D = 3'd0; En = 1'b0; up = 1'b1; sat = 1'b0; clr_flag = 1'b0;
        tick();
        total++; if (Q !== 3'd0) $display("FAIL reset_q: got %0d want 0", Q); else passed++;
        total++; if (wrap !== 1'b0) $display("FAIL reset_wrap: got %b want 0", wrap); else passed++;
        total++; if (limit !== 1'b0) $display("FAIL reset_limit: got %b want 0", limit); else passed++;
    endtask

    task automatic test_wrap_up();
        logic [2:0] exp_q [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
        reset = 1'b1; En = 1'b1; up = 1'b1; sat = 1'b0;
        total++; if (tc !== 1'b0) $display("FAIL up_tc_start: got %b want 0", tc); else passed++;
        for (int i = 0; i < 7; i++) begin
            tick();
            total++; if (Q !== exp_q[i]) $display("FAIL up_q[%0d]: got %0d want %0d", i, Q, exp_q[i]); else passed++;
            total++; if (wrap !== (i == 5)) $display("FAIL up_wrap[%0d]: got %b want %b", i, wrap, i == 5); else passed++;
            total++; if (limit !== (i >= 5)) $display("FAIL up_limit[%0d]: got %b want %b", i, limit, i >= 5); else passed++;
            total++; if (tc !== (i == 4)) $display("FAIL up_tc[%0d]: got %b want %b", i, tc, i == 4); else passed++;
        end
    endtask

    task automatic test_sat_down();
        logic [2:0] exp_q [7] = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0};
        L = 1'b1; D = 3'd7; clr_flag = 1'b1;
        tick();
        total++; if (Q !== 3'd5) $display("FAIL clamp_q: got %0d want 5", Q); else passed++;
        total++; if (limit !== 1'b0) $display("FAIL clamp_clr: got %b want 0", limit); else passed++;
        L = 1'b0; clr_flag = 1'b0; up = 1'b0; sat = 1'b1; En = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            total++; if (Q !== exp_q[i]) $display("FAIL sat_q[%0d]: got %0d want %0d", i, Q, exp_q[i]); else passed++;
            total++; if (wrap !== 1'b0) $display("FAIL sat_wrap[%0d]: got %b want 0", i, wrap); else passed++;
            total++; if (limit !== (i >= 5)) $display("FAIL sat_limit[%0d]: got %b want %b", i, limit, i >= 5); else passed++;
            total++; if (tc !== (i >= 4)) $display("FAIL sat_tc[%0d]: got %b want %b", i, tc, i >= 4); else passed++;
        end
    endtask

    task automatic test_load_priority();
        L = 1'b1; D = 3'd3; sat = 1'b0;
        tick();
        total++; if (Q !== 3'd3) $display("FAIL load3_q: got %0d want 3", Q); else passed++;
        L = 1'b1; En = 1'b1; up = 1'b1; D = 3'd2;
        tick();
        total++; if (Q !== 3'd2) $display("FAIL load_wins_q: got %0d want 2", Q); else passed++;
        L = 1'b0; En = 1'b0;
        total++; if (tc !== 1'b0) $display("FAIL hold_tc: got %b want 0", tc); else passed++;
        tick();
        total++; if (Q !== 3'd2) $display("FAIL hold_q: got %0d want 2", Q); else passed++;
        total++; if (wrap !== 1'b0) $display("FAIL hold_wrap: got %b want 0", wrap); else passed++;
    endtask

    task automatic test_clr_vs_set();
        L = 1'b1; D = 3'd5; En = 1'b1; up = 1'b1; sat = 1'b1;
        #1;
        total++; if (tc !== 1'b0) $display("FAIL tc_at2: got %b want 0", tc); else passed++;
        tick();
        total++; if (tc !== 1'b1) $display("FAIL tc_ignores_L: got %b want 1", tc); else passed++;
        total++; if (limit !== 1'b1) $display("FAIL load_keeps_limit: got %b want 1", limit); else passed++;
        L = 1'b0; clr_flag = 1'b1;
        tick();
        total++; if (Q !== 3'd5) $display("FAIL setclr_q: got %0d want 5", Q); else passed++;
        total++; if (limit !== 1'b1) $display("FAIL set_beats_clr: got %b want 1", limit); else passed++;
        total++; if (wrap !== 1'b0) $display("FAIL setclr_wrap: got %b want 0", wrap); else passed++;
        En = 1'b0;
        tick();
        total++; if (limit !== 1'b0) $display("FAIL clr_limit: got %b want 0", limit); else passed++;
        clr_flag = 1'b0;
    endtask

    task automatic test_wrap_down();
        L = 1'b1; D = 3'd0;
        tick();
        L = 1'b0; En = 1'b1; up = 1'b0; sat = 1'b0;
        tick();
        total++; if (Q !== 3'd5) $display("FAIL down_wrap_q: got %0d want 5", Q); else passed++;
        total++; if (wrap !== 1'b1) $display("FAIL down_wrap_pulse: got %b want 1", wrap); else passed++;
        total++; if (limit !== 1'b1) $display("FAIL down_wrap_limit: got %b want 1", limit); else passed++;
        tick();
        total++; if (Q !== 3'd4) $display("FAIL down_after_q: got %0d want 4", Q); else passed++;
        total++; if (wrap !== 1'b0) $display("FAIL down_after_wrap: got %b want 0", wrap); else passed++;
    endtask

    task automatic test_reset_mid();
        L = 1'b1; D = 3'd4;
        tick();
        L = 1'b0; En = 1'b1; up = 1'b1; sat = 1'b0; reset = 1'b0;
        tick();
        total++; if (Q !== 3'd0) $display("FAIL mid_reset_q: got %0d want 0", Q); else passed++;
        total++; if (wrap !== 1'b0) $display("FAIL mid_reset_wrap: got %b want 0", wrap); else passed++;
        total++; if (limit !== 1'b0) $display("FAIL mid_reset_limit: got %b want 0", limit); else passed++;
        reset = 1'b1;
        tick();
        total++; if (Q !== 3'd1) $display("FAIL resume1_q: got %0d want 1", Q); else passed++;
        tick();
        total++; if (Q !== 3'd2) $display("FAIL resume2_q: got %0d want 2", Q); else passed++;
        L = 1'b1; D = 3'd3; reset = 1'b0;
        tick();
        total++; if (Q !== 3'd0) $display("FAIL reset_over_load: got %0d want 0", Q); else passed++;
        reset = 1'b1; L = 1'b0; En = 1'b0;
    endtask

    task automatic test_cascade();
        int hi_wraps = 0;
        c_reset = 1'b0; c_en = 1'b0;
        tick();
        total++; if ({hi_q, lo_q} !== 8'h00) $display("FAIL casc_reset: got %h want 00", {hi_q, lo_q}); else passed++;
        c_reset = 1'b1; c_en = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            tick();
            total++;
            if (int'(hi_q) * 10 + int'(lo_q) !== k % 100)
                $display("FAIL casc_count[%0d]: got %0d%0d want %0d", k, hi_q, lo_q, k % 100);
            else passed++;
            if (hi_wrap === 1'b1) hi_wraps++;
        end
        total++; if (hi_wrap !== 1'b1) $display("FAIL casc_hi_wrap_at_100: got %b want 1", hi_wrap); else passed++;
        total++; if (hi_wraps !== 1) $display("FAIL casc_hi_wrap_count: got %0d want 1", hi_wraps); else passed++;
        c_en = 1'b0;
    endtask

    initial begin
        c_reset = 1'b0; c_en = 1'b0;
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_load_priority();
        test_clr_vs_set();
        test_wrap_down();
        test_reset_mid();
        test_cascade();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
